// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter, threshold flags and status pulses.
// Optional first-word-fall-through read port selected by FWFT.
module sync_fifo #(
    parameter int DSIZE    = 8,
    parameter int ASIZE    = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2,
    parameter bit FWFT     = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ASIZE:0]   count,
    output logic             wr_ack,
    output logic             rd_valid,
    output logic             overflow,
    output logic             underflow
);

    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] ONE   = {{ASIZE{1'b0}}, 1'b1};
    localparam logic [ASIZE:0] AF_TH = AF_LEVEL[ASIZE:0];
    localparam logic [ASIZE:0] AE_TH = AE_LEVEL[ASIZE:0];

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE:0]   wptr;
    logic [ASIZE:0]   rptr;
    logic             wr_en;
    logic             rd_en;

    // Status decoded from registered pointers and count only (no bypass)
    always_comb begin
        rempty       = (wptr == rptr);
        wfull        = (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]) &&
                       (wptr[ASIZE] != rptr[ASIZE]);
        almost_full  = (count >= AF_TH);
        almost_empty = (count <= AE_TH);
        wr_en        = winc && !wfull && !flush;
        rd_en        = rinc && !rempty && !flush;
    end

    // Pointer and occupancy bookkeeping; flush clears to empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) wptr <= wptr + ONE;
            if (rd_en) rptr <= rptr + ONE;
            unique case (1'b1)
                wr_en && !rd_en: count <= count + ONE;
                rd_en && !wr_en: count <= count - ONE;
                default:         count <= count;
            endcase
        end
    end

    // Storage array, deliberately left without reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[ASIZE-1:0]] <= wdata;
    end

    // One-cycle status pulses for accepted and rejected requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_en;
            overflow  <= winc && wfull && !flush;
            underflow <= rinc && rempty && !flush;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is always visible; valid whenever not empty
            always_comb begin
                rdata    = mem[rptr[ASIZE-1:0]];
                rd_valid = !rempty;
            end
        end else begin : g_std
            logic [DSIZE-1:0] rdata_q;
            logic             rvld_q;

            // Registered read: data and qualifier one cycle after the pop
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                    rvld_q  <= 1'b0;
                end else begin
                    rvld_q <= rd_en;
                    if (rd_en) rdata_q <= mem[rptr[ASIZE-1:0]];
                end
            end

            // Drive ports from the read registers
            always_comb begin
                rdata    = rdata_q;
                rd_valid = rvld_q;
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: standard and FWFT instances share stimulus.
// Expected values are hand-derived per step.
module tb_sync_fifo;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       winc;
    logic [7:0] wdata;
    logic       rinc;

    logic [7:0] rdata0, rdata1;
    logic       wfull0, wfull1;
    logic       rempty0, rempty1;
    logic       af0, af1;
    logic       ae0, ae1;
    logic [4:0] count0, count1;
    logic       wr_ack0, wr_ack1;
    logic       rd_valid0, rd_valid1;
    logic       ovf0, ovf1;
    logic       unf0, unf1;

    int checks;
    int failures;

    sync_fifo #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .winc(winc), .wdata(wdata),
        .rinc(rinc), .rdata(rdata0), .wfull(wfull0), .rempty(rempty0),
        .almost_full(af0), .almost_empty(ae0), .count(count0), .wr_ack(wr_ack0),
        .rd_valid(rd_valid0), .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .winc(winc), .wdata(wdata),
        .rinc(rinc), .rdata(rdata1), .wfull(wfull1), .rempty(rempty1),
        .almost_full(af1), .almost_empty(ae1), .count(count1), .wr_ack(wr_ack1),
        .rd_valid(rd_valid1), .overflow(ovf1), .underflow(unf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 32'(count0), 32'd0);
        check({tag, "_rempty"}, 32'(rempty0), 32'd1);
        check({tag, "_aempty"}, 32'(ae0), 32'd1);
        check({tag, "_wfull"}, 32'(wfull0), 32'd0);
        check({tag, "_afull"}, 32'(af0), 32'd0);
        check({tag, "_wr_ack"}, 32'(wr_ack0), 32'd0);
        check({tag, "_rd_valid"}, 32'(rd_valid0), 32'd0);
        check({tag, "_overflow"}, 32'(ovf0), 32'd0);
        check({tag, "_underflow"}, 32'(unf0), 32'd0);
        check({tag, "_rdata"}, 32'(rdata0), 32'd0);
        check({tag, "_fwft_valid"}, 32'(rd_valid1), 32'd0);
        check({tag, "_fwft_count"}, 32'(count1), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        winc  = 1'b0;
        rinc  = 1'b0;
        wdata = '0;
        #3;
        check_reset_state("reset");
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();

        // Fill 1..16 with threshold tracking
        for (int i = 1; i <= 16; i++) begin
            winc  = 1'b1;
            wdata = 8'(i);
            tick();
            check("fill_ack", 32'(wr_ack0), 32'd1);
            check("fill_count", 32'(count0), 32'(i));
            check("fill_ae", 32'(ae0), (i <= 2) ? 32'd1 : 32'd0);
            check("fill_af", 32'(af0), (i >= 12) ? 32'd1 : 32'd0);
            check("fill_full", 32'(wfull0), (i == 16) ? 32'd1 : 32'd0);
        end
        wdata = 8'd99;
        tick();
        check("ovf_pulse", 32'(ovf0), 32'd1);
        check("ovf_no_ack", 32'(wr_ack0), 32'd0);
        check("ovf_count", 32'(count0), 32'd16);
        winc = 1'b0;
        tick();
        check("ovf_clear", 32'(ovf0), 32'd0);

        // Drain 16 words in order
        for (int i = 1; i <= 16; i++) begin
            rinc = 1'b1;
            tick();
            check("drain_valid", 32'(rd_valid0), 32'd1);
            check("drain_data", 32'(rdata0), 32'(i));
            check("drain_count", 32'(count0), 32'(16 - i));
        end
        check("drain_empty", 32'(rempty0), 32'd1);
        tick();
        check("unf_pulse", 32'(unf0), 32'd1);
        check("unf_valid", 32'(rd_valid0), 32'd0);
        rinc = 1'b0;
        tick();
        check("unf_clear", 32'(unf0), 32'd0);

        // Prime 5 words, then stream across a pointer wrap
        for (int i = 0; i < 5; i++) begin
            winc  = 1'b1;
            wdata = 8'(100 + i);
            tick();
        end
        check("prime_count", 32'(count0), 32'd5);
        for (int k = 0; k < 40; k++) begin
            winc  = 1'b1;
            rinc  = 1'b1;
            wdata = 8'(105 + k);
            tick();
            check("stream_count", 32'(count0), 32'd5);
            check("stream_data", 32'(rdata0), 32'(100 + k));
            check("stream_valid", 32'(rd_valid0), 32'd1);
            check("stream_flags", 32'({ovf0, unf0}), 32'd0);
        end
        winc = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("tail_data", 32'(rdata0), 32'(140 + k));
        end
        rinc = 1'b0;
        tick();
        check("tail_empty", 32'(rempty0), 32'd1);

        // Both requests at empty: write wins, read rejected
        winc  = 1'b1;
        rinc  = 1'b1;
        wdata = 8'h55;
        tick();
        check("both0_unf", 32'(unf0), 32'd1);
        check("both0_ack", 32'(wr_ack0), 32'd1);
        check("both0_count", 32'(count0), 32'd1);
        check("both0_valid", 32'(rd_valid0), 32'd0);
        rinc = 1'b0;
        for (int i = 0; i < 15; i++) begin
            wdata = 8'(i + 16'h60);
            tick();
        end
        check("refill_full", 32'(wfull0), 32'd1);

        // Both requests at full: read wins, write rejected
        rinc  = 1'b1;
        wdata = 8'hEE;
        tick();
        check("both16_ovf", 32'(ovf0), 32'd1);
        check("both16_count", 32'(count0), 32'd15);
        check("both16_data", 32'(rdata0), 32'h55);
        check("both16_valid", 32'(rd_valid0), 32'd1);
        winc = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        rinc = 1'b0;
        tick();
        check("preflush_count", 32'(count0), 32'd9);

        // Flush overrides a concurrent write
        flush = 1'b1;
        winc  = 1'b1;
        wdata = 8'h33;
        tick();
        check("flush_count", 32'(count0), 32'd0);
        check("flush_empty", 32'(rempty0), 32'd1);
        check("flush_ack", 32'(wr_ack0), 32'd0);
        check("flush_valid", 32'(rd_valid0), 32'd0);
        flush = 1'b0;
        winc  = 1'b0;
        tick();
        check("post_flush_count", 32'(count0), 32'd0);

        // FWFT instance: word falls through with no read request
        winc  = 1'b1;
        wdata = 8'hA5;
        tick();
        check("fwft_data", 32'(rdata1), 32'hA5);
        check("fwft_valid", 32'(rd_valid1), 32'd1);
        winc = 1'b0;
        rinc = 1'b1;
        tick();
        check("fwft_pop_empty", 32'(rempty1), 32'd1);
        check("fwft_pop_valid", 32'(rd_valid1), 32'd0);
        check("std_pop_data", 32'(rdata0), 32'hA5);
        rinc = 1'b0;

        // Asynchronous reset in the middle of traffic
        winc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wdata = 8'(i + 16'hC0);
            tick();
        end
        check("pre_rst_count", 32'(count0), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        winc = 1'b0;
        tick();
        #2 rst_n = 1'b1;
        tick();

        // First write after reset must occupy address 0
        winc  = 1'b1;
        wdata = 8'h77;
        tick();
        check("post_rst_count", 32'(count0), 32'd1);
        check("post_rst_fwft", 32'(rdata1), 32'h77);
        winc = 1'b0;
        rinc = 1'b1;
        tick();
        check("post_rst_data", 32'(rdata0), 32'h77);
        check("post_rst_valid", 32'(rd_valid0), 32'd1);
        rinc = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
